// File: rtl/sample_loader.sv
// sample_loader: front-end of the FFT sample memory.
// Turns a host-driven load strobe plus a packed sample byte (real [7:4],
// imag [3:0]) into one-cycle write pulses with auto-incrementing addresses.
// After NUM_SAMPLES loads it issues a one-cycle FFT start and refuses further
// loads until the core reports done. Strobe edges that arrive while busy are
// dropped and recorded in a sticky overrun flag.
// Optional build macro: LOADER_SYNC_EN adds a 2-flop synchroniser on
// strobe_in for hosts that are asynchronous to clk (2 extra cycles of latency).
module sample_loader #(
  parameter int NUM_SAMPLES = 4,
  parameter int ADDR_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic              i_clear,
  input  logic              i_strobe_in,
  input  logic [7:0]        i_data_in_ext,
  input  logic              i_fft_done,
  output logic              o_load_pulse,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_data_out,
  output logic              o_fft_start,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_START   = 2'd2;
  localparam logic [1:0] S_COMPUTE = 2'd3;

  // Address of the final sample in a frame; loading it closes the frame.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_count;
  logic              r_load_pulse;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data_out;
  logic              r_fft_start;
  logic              r_busy;
  logic              r_overrun;
  logic              r_strobe_prev;
  logic              w_strobe_s;
  logic              w_edge;

`ifdef LOADER_SYNC_EN
  logic r_sync_1;
  logic r_sync_2;

  // Two-stage synchroniser for an asynchronous host strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_1 <= 1'b0;
      r_sync_2 <= 1'b0;
    end else begin
      r_sync_1 <= i_strobe_in;
      r_sync_2 <= r_sync_1;
    end
  end

  assign w_strobe_s = r_sync_2;
`else
  assign w_strobe_s = i_strobe_in;
`endif

  // Strobe history; tracks every cycle so edges during ena=0 are consumed, not deferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe_prev <= 1'b0;
    end else begin
      r_strobe_prev <= w_strobe_s;
    end
  end

  assign w_edge = w_strobe_s & ~r_strobe_prev;

  // Frame FSM: fill addresses, fire start, wait for done; clear aborts, ena gates.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_load_pulse <= 1'b0;
      r_addr       <= '0;
      r_data_out   <= 8'h00;
      r_fft_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (i_clear) begin
      // addr and data_out deliberately hold their last values.
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_load_pulse <= 1'b0;
      r_fft_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (!i_ena) begin
      r_load_pulse <= 1'b0;
      r_fft_start  <= 1'b0;
    end else begin
      r_load_pulse <= 1'b0;
      r_fft_start  <= 1'b0;
      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_edge) begin
            r_load_pulse <= 1'b1;
            r_addr       <= r_count;
            r_data_out   <= i_data_in_ext;
            r_count      <= r_count + 1'b1;
            if (r_count == LAST_ADDR) begin
              r_state <= S_START;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_START: begin
          r_fft_start <= 1'b1;
          r_busy      <= 1'b1;
          r_count     <= '0;
          r_state     <= S_COMPUTE;
          if (w_edge) begin
            r_overrun <= 1'b1;
          end
        end
        S_COMPUTE: begin
          if (w_edge) begin
            r_overrun <= 1'b1;
          end
          if (i_fft_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_load_pulse = r_load_pulse;
  assign o_addr       = r_addr;
  assign o_data_out   = r_data_out;
  assign o_fft_start  = r_fft_start;
  assign o_busy       = r_busy;
  assign o_overrun    = r_overrun;

endmodule
